// File: rtl/alu_pipe_adder_pkg.sv
// alu_pipe_adder_pkg: shared ALU slice width and add/sub opcode encoding
package alu_pipe_adder_pkg;
  localparam int SLICE_W = 4;
  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} alu_op_e;
endpackage

// File: rtl/alu_pipe_adder_add4_slice.sv
// add4_slice: one 4-bit add slice built on the 3-bit lookahead carry unit
module add4_slice
  import alu_pipe_adder_pkg::*;
(
  input  logic               cin,
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  output logic [SLICE_W-1:0] s,
  output logic               c_msb_in,
  output logic               c_out
);
  logic [SLICE_W-1:0] g, p;
  logic [3:1] c;
  assign g = x & y;
  assign p = x ^ y;
  carry_logic u_carry (.g(g[2:0]), .p(p[2:0]), .cin(cin), .c(c));
  assign c_out = g[3] | p[3] & c[3];
  assign c_msb_in = c[3];
  assign s = p ^ {c[3:1], cin};
endmodule

// File: rtl/alu_pipe_adder_carry_logic.sv
// carry_logic: 3-bit lookahead carry unit producing c1..c3 from generate/propagate
module carry_logic (
  input  logic [2:0] g,
  input  logic [2:0] p,
  input  logic       cin,
  output logic [3:1] c
);
  assign c[1] = g[0] | p[0] & cin;
  assign c[2] = g[1] | p[1] & g[0] | p[1] & p[0] & cin;
  assign c[3] = g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | p[2] & p[1] & p[0] & cin;
endmodule

// File: rtl/alu_pipe_adder.sv
// alu_pipe_adder: slice-per-stage pipelined add/subtract with C/V/Z flags and valid/ready
module alu_pipe_adder
  import alu_pipe_adder_pkg::*;
#(
  parameter int SLICES = 4,
  localparam int W = SLICE_W * SLICES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);
  logic [W-1:0] a_r [SLICES-1];
  logic [W-1:0] b_r [SLICES-1];
  logic [W-1:0] s_r [SLICES];
  logic [SLICE_W-1:0] s_n [SLICES];
  logic [SLICES-1:0] v_r, c_r, c_out, c_msb;
  logic [W-1:0] b_in, sum_n;
  logic adv, ovf_r, zero_r, unused;
  assign adv = !v_r[SLICES-1] | out_ready;
  assign in_ready = adv;
  assign b_in = b ^ {W{sub}};
  assign sum_n = {s_n[SLICES-1], s_r[SLICES-2][W-SLICE_W-1:0]};
  assign unused = ^{c_msb[SLICES-2:0], s_r[SLICES-2][W-1-:SLICE_W],
                    a_r[SLICES-2][W-SLICE_W-1:0], b_r[SLICES-2][W-SLICE_W-1:0]};
  for (genvar k = 0; k < SLICES; k++) begin : g_st
    logic [SLICE_W-1:0] x, y;
    logic ci;
    if (k == 0) begin : g_first
      assign x = a[SLICE_W-1:0];
      assign y = b_in[SLICE_W-1:0];
      assign ci = sub;
    end else begin : g_next
      assign x = a_r[k-1][k*SLICE_W+:SLICE_W];
      assign y = b_r[k-1][k*SLICE_W+:SLICE_W];
      assign ci = c_r[k-1];
    end
    add4_slice u_slice (.cin(ci), .x(x), .y(y), .s(s_n[k]), .c_msb_in(c_msb[k]), .c_out(c_out[k]));
  end
  // All stages shift together on advance and hold together on stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_r <= '0;
      c_r <= '0;
      ovf_r <= 1'b0;
      zero_r <= 1'b0;
      for (int k = 0; k < SLICES - 1; k++) begin
        a_r[k] <= '0;
        b_r[k] <= '0;
      end
      for (int k = 0; k < SLICES; k++) s_r[k] <= '0;
    end else if (adv) begin
      v_r <= {v_r[SLICES-2:0], in_valid};
      c_r <= c_out;
      a_r[0] <= a;
      b_r[0] <= b_in;
      s_r[0] <= W'(s_n[0]);
      for (int k = 1; k < SLICES - 1; k++) begin
        a_r[k] <= a_r[k-1];
        b_r[k] <= b_r[k-1];
      end
      for (int k = 1; k < SLICES; k++) begin
        s_r[k] <= s_r[k-1];
        s_r[k][k*SLICE_W+:SLICE_W] <= s_n[k];
      end
      ovf_r <= c_msb[SLICES-1] ^ c_out[SLICES-1];
      zero_r <= ~|sum_n;
    end
  end
  assign out_valid = v_r[SLICES-1];
  assign sum = s_r[SLICES-1];
  assign cout = c_r[SLICES-1];
  assign ovf = ovf_r;
  assign zero = zero_r;
endmodule

// File: tb/tb_alu_pipe_adder.sv
// tb_alu_pipe_adder: directed vector table plus stall and async-reset sequences
module tb_alu_pipe_adder;
  import alu_pipe_adder_pkg::*;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, sub, out_valid, out_ready, cout, ovf, zero;
  logic [15:0] a, b, sum;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;
  vec_t tv[7];
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  alu_pipe_adder #(.SLICES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  task automatic drive(input int i);
    a = tv[i].a;
    b = tv[i].b;
    sub = tv[i].sub;
  endtask
  task automatic chk_res(input string nm, input int i);
    chk({nm, "_sum"}, 32'(sum), 32'(tv[i].s));
    chk({nm, "_cout"}, 32'(cout), 32'(tv[i].c));
    chk({nm, "_ovf"}, 32'(ovf), 32'(tv[i].v));
    chk({nm, "_zero"}, 32'(zero), 32'(tv[i].z));
  endtask
  task automatic single(input int i);
    @(negedge clk);
    chk($sformatf("idle_%0d", i), 32'(out_valid), 0);
    drive(i);
    in_valid = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("lat_%0d_%0d", i, e), 32'(out_valid), 32'(e == 4));
    end
    chk_res($sformatf("vec%0d", i), i);
  endtask
  initial begin
    int q[$];
    int nxt, got, idx;
    logic [15:0] held;
    logic stalled;
    tv[0] = '{16'h00FF, 16'h0001, OP_ADD, 16'h0100, 1'b0, 1'b0, 1'b0};
    tv[1] = '{16'hFFFF, 16'h0001, OP_ADD, 16'h0000, 1'b1, 1'b0, 1'b1};
    tv[2] = '{16'h7FFF, 16'h0001, OP_ADD, 16'h8000, 1'b0, 1'b1, 1'b0};
    tv[3] = '{16'h8000, 16'h0001, OP_SUB, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    tv[4] = '{16'h0005, 16'h0007, OP_SUB, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    tv[5] = '{16'h1234, 16'h1234, OP_SUB, 16'h0000, 1'b1, 1'b0, 1'b1};
    tv[6] = '{16'h0001, 16'h0001, OP_ADD, 16'h0002, 1'b0, 1'b0, 1'b0};
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    sub = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_flags", 32'({cout, ovf, zero}), 0);
    rst = 1'b0;
    #1 chk("rst_in_ready", 32'(in_ready), 1);
    for (int i = 0; i < 7; i++) single(i);
    nxt = 0;
    got = 0;
    stalled = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 5 && cyc < 8);
      in_valid = nxt < 6;
      if (nxt < 6) drive(nxt);
      #1;
      chk("stream_in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (out_valid && !out_ready) begin
        if (stalled) chk("stream_hold", 32'(sum), 32'(held));
        held = sum;
        stalled = 1'b1;
      end else stalled = 1'b0;
      if (out_valid && out_ready) begin
        chk("stream_expected", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          idx = q.pop_front();
          chk_res($sformatf("stream%0d", idx), idx);
          got++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(nxt);
        nxt++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_got", 32'(got), 6);
    chk("stream_issued", 32'(nxt), 6);
    #1 chk("stream_no_dup", 32'(out_valid), 0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(i);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid), 1);
    #2 rst = 1'b1;
    #1 chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_sum", 32'(sum), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_stale", 32'(out_valid), 0);
    end
    single(6);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
